ps2_receiver: RTL and testbench
===============================

// Module: ps2_receiver
// PURPOSE
//   Deserialises the raw PS/2 keyboard clock/data lines into one byte per frame.
//   It sits directly upstream of the keycode recognizer and drives its
//   ps2_key_en / ps2_key_data inputs: one key_en strobe per valid scan-code byte.
//   Bad frames are dropped and reported on error strobes.
// PARAMETERS
//   SYNC_STAGES     2       flops in each input synchroniser (>=2)
//   FILTER_LEN      8       consecutive clk samples needed before filtered ps2_clk changes
//   TIMEOUT_CYCLES  100000  clk cycles without a ps2_clk fall mid-frame before abort (2 ms @ 50 MHz)
// PORTS
//   clk         in   1  system clock
//   reset_n     in   1  asynchronous, active-low reset
//   ps2_clk     in   1  raw PS/2 clock from pad, asynchronous, idles high
//   ps2_dat     in   1  raw PS/2 data from pad, asynchronous, idles high
//   key_en      out  1  one-cycle strobe: key_data holds a new valid byte
//   key_data    out  8  last good byte; held until the next good frame
//   parity_err  out  1  one-cycle strobe: frame dropped, odd parity failed
//   frame_err   out  1  one-cycle strobe: frame dropped, bad stop bit or timeout
// BEHAVIOUR
//   Reset: key_en=0, key_data=8'h00, parity_err=0, frame_err=0, FSM=IDLE.
//     Synchroniser and filter flops reset to 1, so releasing reset never fakes an edge.
//   Input path: both lines go through SYNC_STAGES flops. ps2_clk is also filtered.
//     The filter counts cycles where the synced value differs from the filtered value.
//     The count clears whenever they are equal.
//     Filtered value takes the synced value after FILTER_LEN consecutive mismatches.
//     ps2_dat is synchronised only; it is sampled on a filtered clock fall.
//   fall = registered 1->0 transition of filtered ps2_clk. All bit sampling uses fall only.
//   FSM (frame = start, 8 data LSB first, odd parity, stop):
//     IDLE   : fall & dat=0 -> DATA with bit_cnt=0. fall & dat=1 -> stay, ignored.
//     DATA   : on fall, sr <= {dat, sr[7:1]} and bit_cnt++. After the 8th bit -> PARITY.
//     PARITY : on fall, latch p -> STOP.
//     STOP   : on fall, exit to IDLE, with the outcome in priority order:
//       dat=0             -> frame_err pulse.
//       (^sr ^ p)=0       -> parity_err pulse.
//       otherwise         -> key_data<=sr, key_en pulse.
//   Every outcome strobe is high exactly one clk cycle. Strobes are mutually exclusive.
//     At most one strobe fires per frame.
//   Latency: key_en rises SYNC_STAGES+FILTER_LEN+1 clk cycles after the raw ps2_clk
//     fall of the stop bit. This latency is fixed; the bench checks it exactly.
//   Timeout: in any state but IDLE, a watchdog counts clk cycles since the last fall.
//     The counter clears on each fall. Reaching TIMEOUT_CYCLES -> frame_err pulse,
//     FSM to IDLE, partial byte discarded. The watchdog is idle in IDLE.
//   The watchdog counter is $clog2(TIMEOUT_CYCLES+1) bits wide and saturates; it never wraps.
//   key_data changes only together with key_en. Errors never alter key_data.
//   The block is receive only and never drives the PS/2 lines.
//   Back-to-back frames need no idle gap: IDLE accepts the next start bit on the next fall.
//   Asynchronous reset mid-frame: immediate return to IDLE, partial byte lost, no strobe.
//     The resumed line is treated as fresh; a high data bit in IDLE is ignored.
// TESTING  (PS/2 bit period 80 us, 50 MHz clk, default parameters)
//   1. Frame 0x1C, p=0, stop=1 -> one key_en pulse, key_data=8'h1C, no error strobes,
//      latency = 11 cycles from the raw stop-bit fall.
//   2. Back-to-back E0, F0, 74 -> three key_en pulses with key_data 8'hE0, 8'hF0, 8'h74 in order.
//   3. 0x1C with p=1 -> parity_err pulse once, no key_en, key_data keeps its prior value.
//      Then 0x1C with stop=0 -> frame_err pulse only.
//   4. Start plus 4 data bits, then line idle -> frame_err exactly TIMEOUT_CYCLES after the
//      last fall. A following good 0x5A frame -> key_en, key_data=8'h5A.
//   5. In IDLE, 3-cycle low glitch on ps2_clk with ps2_dat=0 -> no state change, no strobes.
//      Same glitch during DATA -> no extra bit shifted in, frame still decodes correctly.
//   6. Assert reset_n=0 after bit 5 of a frame, release, then send 0x29 -> all outputs at
//      reset values during reset, no strobe, then key_data=8'h29 with a single key_en.

Source files
------------

// File: rtl/ps2_receiver.sv
// PS/2 receive-only deserialiser: synchronises and deglitches the pad lines,
// then assembles start/8 data/odd parity/stop frames into one byte strobe each.
module ps2_receiver #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       key_en,
  output logic [7:0] key_data,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   clk_s;
  logic                   dat_s;
  logic [FW-1:0]          filt_cnt;
  logic                   clk_filt;
  logic                   clk_filt_d;
  logic                   fall;

  state_t        state;
  logic [7:0]    sr;
  logic [2:0]    bit_cnt;
  logic          par;
  logic [WW-1:0] wd;

  // Everything resets to the idle-high line level so reset release cannot look like a fall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync <= '1;
      dat_sync <= '1;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat};
    end
  end

  assign clk_s = clk_sync[SYNC_STAGES-1];
  assign dat_s = dat_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_cnt   <= '0;
      clk_filt   <= 1'b1;
      clk_filt_d <= 1'b1;
    end else begin
      clk_filt_d <= clk_filt;
      if (clk_s == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_s;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign fall = clk_filt_d & ~clk_filt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      sr         <= 8'h00;
      bit_cnt    <= 3'd0;
      par        <= 1'b0;
      wd         <= '0;
      key_en     <= 1'b0;
      key_data   <= 8'h00;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      key_en     <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;

      if (state == IDLE || fall) begin
        wd <= '0;
      end else if (wd != WW'(TIMEOUT_CYCLES)) begin
        wd <= wd + 1'b1;
      end

      case (state)
        IDLE: begin
          if (fall && !dat_s) begin
            state   <= DATA;
            bit_cnt <= 3'd0;
          end
        end
        DATA: begin
          if (fall) begin
            sr      <= {dat_s, sr[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
        end
        PARITY: begin
          if (fall) begin
            par   <= dat_s;
            state <= STOP;
          end
        end
        STOP: begin
          if (fall) begin
            state <= IDLE;
            if (!dat_s) begin
              frame_err <= 1'b1;
            end else if ((^sr ^ par) == 1'b0) begin
              parity_err <= 1'b1;
            end else begin
              key_data <= sr;
              key_en   <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Line went quiet mid-frame: abort; wd hits TIMEOUT_CYCLES-1 exactly TIMEOUT_CYCLES cycles after the last fall.
      if (state != IDLE && !fall && wd == WW'(TIMEOUT_CYCLES - 1)) begin
        frame_err <= 1'b1;
        state     <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_ps2_receiver.sv
// Directed bench for ps2_receiver: frames, parity/stop errors, timeout, glitches, reset.
module tb_ps2_receiver;

  localparam int SYNC    = 2;
  localparam int FILT    = 8;
  localparam int TMO     = 300;
  localparam int HALF    = 20;
  localparam int LATENCY = SYNC + FILT + 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       key_en;
  logic [7:0] key_data;
  logic       parity_err;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int par_cnt = 0;
  int frm_cnt = 0;
  logic prev_en = 1'b0;
  logic [7:0] data_q[$];

  ps2_receiver #(.SYNC_STAGES(SYNC), .FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .key_en(key_en), .key_data(key_data), .parity_err(parity_err), .frame_err(frame_err)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] mk(input logic [7:0] b, input logic p, input logic stop);
    return {stop, p, b, 1'b0};
  endfunction

  // Sends bits f[0..n-1]; optional 3-cycle clock glitch in the high phase after bit glitch_at.
  task automatic send_bits(input logic [10:0] f, input int n, input int glitch_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2_dat = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
      if (i == glitch_at) begin
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (key_en) begin
        en_cnt++;
        data_q.push_back(key_data);
        check("en_width", {31'd0, prev_en}, 32'd0);
      end
      if (parity_err) par_cnt++;
      if (frame_err) frm_cnt++;
      if (key_en || parity_err || frame_err)
        check("excl", 32'(key_en) + 32'(parity_err) + 32'(frame_err), 32'd1);
    end
    prev_en = key_en;
  end

  initial begin
    int cyc;
    repeat (5) @(negedge clk);
    check("rst_en", {31'd0, key_en}, 32'd0);
    check("rst_data", {24'd0, key_data}, 32'h00);
    check("rst_perr", {31'd0, parity_err}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: 0x1C with exact latency from the raw stop-bit fall
    send_bits(mk(8'h1C, 1'b0, 1'b1), 10, -1);
    @(negedge clk);
    ps2_dat = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    for (int i = 1; i <= LATENCY; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("lat_c%0d", i), {31'd0, key_en}, {31'd0, (i == LATENCY)});
    end
    @(negedge clk);
    repeat (HALF - LATENCY - 1) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (5) @(negedge clk);
    check("t1_en_cnt", en_cnt, 1);
    check("t1_q0", {24'd0, data_q[0]}, 32'h1C);
    check("t1_data", {24'd0, key_data}, 32'h1C);
    check("t1_errs", par_cnt + frm_cnt, 0);

    // 2: back-to-back E0 F0 74
    send_bits(mk(8'hE0, 1'b0, 1'b1), 11, -1);
    send_bits(mk(8'hF0, 1'b1, 1'b1), 11, -1);
    send_bits(mk(8'h74, 1'b1, 1'b1), 11, -1);
    repeat (5) @(negedge clk);
    check("t2_en_cnt", en_cnt, 4);
    check("t2_q1", {24'd0, data_q[1]}, 32'hE0);
    check("t2_q2", {24'd0, data_q[2]}, 32'hF0);
    check("t2_q3", {24'd0, data_q[3]}, 32'h74);

    // 3: parity error, then bad stop bit
    send_bits(mk(8'h1C, 1'b1, 1'b1), 11, -1);
    repeat (5) @(negedge clk);
    check("t3_perr", par_cnt, 1);
    check("t3_en", en_cnt, 4);
    check("t3_hold", {24'd0, key_data}, 32'h74);
    send_bits(mk(8'h1C, 1'b0, 1'b0), 11, -1);
    repeat (5) @(negedge clk);
    check("t3_ferr", frm_cnt, 1);
    check("t3_perr2", par_cnt, 1);
    check("t3_en2", en_cnt, 4);
    check("t3_hold2", {24'd0, key_data}, 32'h74);

    // 4: start + 4 data bits then silence -> timeout
    send_bits(mk(8'h0F, 1'b1, 1'b1), 4, -1);
    @(negedge clk);
    ps2_dat = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    cyc = 0;
    fork
      begin
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
      end
      begin
        while (!frame_err && cyc < LATENCY + TMO + 50) begin
          @(posedge clk);
          #1;
          cyc++;
        end
      end
    join
    check("t4_tmo_cycles", cyc, LATENCY + TMO);
    repeat (5) @(negedge clk);
    check("t4_ferr", frm_cnt, 2);
    check("t4_hold", {24'd0, key_data}, 32'h74);
    send_bits(mk(8'h5A, 1'b1, 1'b1), 11, -1);
    repeat (5) @(negedge clk);
    check("t4_en", en_cnt, 5);
    check("t4_data", {24'd0, key_data}, 32'h5A);

    // 5: glitches in IDLE and during DATA
    @(negedge clk);
    ps2_dat = 1'b0;
    repeat (10) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (40) @(negedge clk);
    check("t5_idle_strobes", en_cnt + par_cnt + frm_cnt, 5 + 1 + 2);
    send_bits(mk(8'h3B, 1'b0, 1'b1), 11, 3);
    repeat (5) @(negedge clk);
    check("t5_en", en_cnt, 6);
    check("t5_data", {24'd0, key_data}, 32'h3B);
    check("t5_errs", par_cnt + frm_cnt, 3);

    // 6: reset after bit 5, stray high bit, then 0x29
    send_bits(mk(8'hA6, 1'b1, 1'b1), 6, -1);
    @(negedge clk);
    ps2_dat = 1'b1;
    reset_n = 1'b0;
    #1;
    check("t6_rst_en", {31'd0, key_en}, 32'd0);
    check("t6_rst_data", {24'd0, key_data}, 32'h00);
    check("t6_rst_perr", {31'd0, parity_err}, 32'd0);
    check("t6_rst_ferr", {31'd0, frame_err}, 32'd0);
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    send_bits(11'h7FF, 1, -1);
    repeat (30) @(negedge clk);
    check("t6_quiet", en_cnt + par_cnt + frm_cnt, 6 + 1 + 2);
    send_bits(mk(8'h29, 1'b0, 1'b1), 11, -1);
    repeat (5) @(negedge clk);
    check("t6_en", en_cnt, 7);
    check("t6_data", {24'd0, key_data}, 32'h29);
    check("t6_errs", par_cnt + frm_cnt, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
